// File: rtl/spi_fsm_pkg.sv
// ----------------------------------------------------------------------------
// spi_fsm_pkg
// Shared definitions for the SPI slave control FSM:
//   - default frame width and bit-counter width
//   - state encodings (also shown on the LED debug port) and the state enum
// ----------------------------------------------------------------------------
package spi_fsm_pkg;

    localparam int WIDTH_DEFAULT = 8;  // 7 address bits + R/W, or one data byte
    localparam int CNT_W_DEFAULT = 4;  // must satisfy 2**CNT_W > WIDTH

    localparam logic [2:0] ENC_IDLE         = 3'd0;
    localparam logic [2:0] ENC_GET_ADDR     = 3'd1;
    localparam logic [2:0] ENC_GOT_ADDR     = 3'd2;
    localparam logic [2:0] ENC_READ_LOAD    = 3'd3;
    localparam logic [2:0] ENC_READ_SHIFT   = 3'd4;
    localparam logic [2:0] ENC_WRITE_RECV   = 3'd5;
    localparam logic [2:0] ENC_WRITE_COMMIT = 3'd6;
    localparam logic [2:0] ENC_DONE         = 3'd7;

    typedef enum logic [2:0] {
        IDLE         = ENC_IDLE,
        GET_ADDR     = ENC_GET_ADDR,
        GOT_ADDR     = ENC_GOT_ADDR,
        READ_LOAD    = ENC_READ_LOAD,
        READ_SHIFT   = ENC_READ_SHIFT,
        WRITE_RECV   = ENC_WRITE_RECV,
        WRITE_COMMIT = ENC_WRITE_COMMIT,
        DONE         = ENC_DONE
    } state_t;

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// ----------------------------------------------------------------------------
// bit_counter
// Counts serial-clock edges within one frame phase. Saturates at LIMIT so
// the FSM always sees a stable "phase complete" value and the count never
// wraps back into range.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : synchronous clear, has priority over enable
//   enable     : advance the count by one this cycle
//   count      : current count
// ----------------------------------------------------------------------------
module bit_counter
    import spi_fsm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int LIMIT = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT);

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_fsm.sv
// ----------------------------------------------------------------------------
// spi_fsm
// Control FSM of an SPI slave: receives an address + R/W frame, then either
// loads read data into the shift register and enables MISO for one frame,
// or receives one data frame and commits it to data memory.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   cs         : conditioned chip select, active low
//   sclk_pos   : one-clk pulse per rising serial-clock edge
//   sclk_neg   : one-clk pulse per falling serial-clock edge (not used here)
//   rw_bit     : shift-register bit 0 after the address frame (1 = read)
//   addr_we    : strobe, latch the address
//   sr_we      : strobe, parallel-load read data into the shift register
//   dm_we      : strobe, write received data to data memory
//   miso_bufe  : MISO tri-state enable, high while shifting read data out
//   state_dbg  : current state encoding for LED display
// All outputs are decoded from the registered state only.
// ----------------------------------------------------------------------------
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       sclk_pos,
    input  logic       sclk_neg,
    input  logic       rw_bit,
    output logic       addr_we,
    output logic       sr_we,
    output logic       dm_we,
    output logic       miso_bufe,
    output logic [2:0] state_dbg
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic               cnt_clear;
    logic               cnt_enable;
    logic               counting;
    logic               at_limit;

    // MISO timing is handled outside this block; the falling-edge pulse is
    // accepted on the interface only.
    logic unused_sclk_neg;
    assign unused_sclk_neg = sclk_neg;

    assign counting   = (state == GET_ADDR) || (state == READ_SHIFT) ||
                        (state == WRITE_RECV);
    assign at_limit   = (count == CNT_W'(WIDTH));
    assign cnt_enable = counting && sclk_pos;

    bit_counter #(
        .CNT_W (CNT_W),
        .LIMIT (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        // Deasserted chip select outside IDLE aborts, and is checked before
        // any phase-complete transition so an abort on the final bit never
        // reaches a strobe state.
        if ((state != IDLE) && cs) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs) begin
                        state_next = GET_ADDR;
                        cnt_clear  = 1'b1;
                    end
                end
                GET_ADDR: begin
                    if (at_limit) begin
                        state_next = GOT_ADDR;
                        cnt_clear  = 1'b1;
                    end
                end
                GOT_ADDR:     state_next = rw_bit ? READ_LOAD : WRITE_RECV;
                READ_LOAD:    state_next = READ_SHIFT;
                READ_SHIFT: begin
                    if (at_limit) begin
                        state_next = DONE;
                        cnt_clear  = 1'b1;
                    end
                end
                WRITE_RECV: begin
                    if (at_limit) begin
                        state_next = WRITE_COMMIT;
                        cnt_clear  = 1'b1;
                    end
                end
                WRITE_COMMIT: state_next = DONE;
                DONE:         state_next = DONE;  // leaves via the cs=1 path
                default: begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    // Moore outputs: reset forces IDLE, which forces all of these low at once.
    assign addr_we   = (state == GOT_ADDR);
    assign sr_we     = (state == READ_LOAD);
    assign dm_we     = (state == WRITE_COMMIT);
    assign miso_bufe = (state == READ_SHIFT);
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_fsm.sv
// ----------------------------------------------------------------------------
// tb_spi_fsm
// Directed bench for spi_fsm. Expected strobes are queued when a transaction
// is driven and popped by a monitor as the DUT raises them.
// ----------------------------------------------------------------------------
module tb_spi_fsm;
    import spi_fsm_pkg::*;

    localparam int EV_NONE = 0;
    localparam int EV_ADDR = 1;
    localparam int EV_SR   = 2;
    localparam int EV_DM   = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       cs       = 1'b1;
    logic       sclk_pos = 1'b0;
    logic       sclk_neg = 1'b0;
    logic       rw_bit   = 1'b0;
    logic       addr_we;
    logic       sr_we;
    logic       dm_we;
    logic       miso_bufe;
    logic [2:0] state_dbg;

    int n_checks    = 0;
    int n_fail      = 0;
    int exp_q[$];
    int miso_cycles = 0;
    int miso_pulses = 0;
    int dm_count    = 0;

    always #5 clk = ~clk;

    spi_fsm #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .rw_bit    (rw_bit),
        .addr_we   (addr_we),
        .sr_we     (sr_we),
        .dm_we     (dm_we),
        .miso_bufe (miso_bufe),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input state_t s);
        check(tag, int'(state_dbg), int'(s));
    endtask

    task automatic take(input int code, input string tag);
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : EV_NONE;
        check(tag, code, e);
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (miso_bufe) begin
            miso_cycles++;
            if (sclk_pos) miso_pulses++;
        end
        if (addr_we) take(EV_ADDR, "addr_we_strobe");
        if (sr_we)   take(EV_SR, "sr_we_strobe");
        if (dm_we) begin
            dm_count++;
            take(EV_DM, "dm_we_strobe");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        sclk_pos = 1'b1;
        cycle();
        sclk_pos = 1'b0;
        sclk_neg = 1'b1;
        cycle();
        sclk_neg = 1'b0;
    endtask

    task automatic start();
        cs = 1'b0;
        cycle();
        expect_state("enter_get_addr", GET_ADDR);
    endtask

    task automatic send_addr(input logic rw);
        exp_q.push_back(EV_ADDR);
        if (rw) exp_q.push_back(EV_SR);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                rw_bit = rw;
                expect_state("addr_7_bits", GET_ADDR);
            end
            pulse();
        end
        expect_state("got_addr", GOT_ADDR);
        check("addr_we_high", int'(addr_we), 1);
        cycle();
        rw_bit = 1'b0;
        expect_state("after_addr", rw ? READ_LOAD : WRITE_RECV);
        check("addr_we_one_clk", int'(addr_we), 0);
    endtask

    task automatic do_write();
        int m0;
        start();
        m0 = miso_cycles;
        send_addr(1'b0);
        exp_q.push_back(EV_DM);
        for (int i = 0; i < 8; i++) pulse();
        expect_state("write_commit", WRITE_COMMIT);
        check("dm_we_high", int'(dm_we), 1);
        cycle();
        expect_state("write_done", DONE);
        check("dm_we_one_clk", int'(dm_we), 0);
        check("write_no_miso", miso_cycles - m0, 0);
    endtask

    initial begin
        int p0;
        int d0;

        // Reset state
        #1;
        expect_state("reset_state", IDLE);
        check("reset_addr_we", int'(addr_we), 0);
        check("reset_sr_we", int'(sr_we), 0);
        check("reset_dm_we", int'(dm_we), 0);
        check("reset_miso_bufe", int'(miso_bufe), 0);
        cycle();
        reset = 1'b0;
        cycle();
        expect_state("idle_cs_high", IDLE);

        // Write transaction
        do_write();
        cycle();
        expect_state("done_holds", DONE);
        cs = 1'b1;
        cycle();
        expect_state("done_to_idle", IDLE);

        // Read transaction
        start();
        send_addr(1'b1);
        check("sr_we_high", int'(sr_we), 1);
        p0 = miso_pulses;
        cycle();
        expect_state("read_shift", READ_SHIFT);
        check("sr_we_one_clk", int'(sr_we), 0);
        check("miso_on", int'(miso_bufe), 1);
        for (int i = 0; i < 8; i++) pulse();
        expect_state("read_done", DONE);
        check("miso_off", int'(miso_bufe), 0);
        check("miso_pulse_count", miso_pulses - p0, 8);
        cs = 1'b1;
        cycle();
        expect_state("read_to_idle", IDLE);

        // Abort after 5 data pulses in WRITE_RECV
        start();
        send_addr(1'b0);
        for (int i = 0; i < 5; i++) pulse();
        expect_state("abort_in_recv", WRITE_RECV);
        cs = 1'b1;
        cycle();
        expect_state("abort_to_idle", IDLE);
        check("abort_no_dm_we", int'(dm_we), 0);
        cycle();
        expect_state("abort_stays_idle", IDLE);

        // cs rises together with the 8th address pulse
        start();
        for (int i = 0; i < 7; i++) pulse();
        sclk_pos = 1'b1;
        cs       = 1'b1;
        cycle();
        sclk_pos = 1'b0;
        expect_state("simul_pulse_idle", IDLE);
        check("simul_pulse_no_addr", int'(addr_we), 0);
        cycle();
        expect_state("simul_pulse_stay", IDLE);

        // cs rises on the cycle the counter sits at WIDTH
        start();
        for (int i = 0; i < 7; i++) pulse();
        sclk_pos = 1'b1;
        cycle();
        sclk_pos = 1'b0;
        cs       = 1'b1;
        cycle();
        expect_state("simul_limit_idle", IDLE);
        check("simul_limit_no_addr", int'(addr_we), 0);

        // Async reset mid READ_SHIFT, between clock edges
        start();
        send_addr(1'b1);
        cycle();
        for (int i = 0; i < 3; i++) pulse();
        check("pre_reset_miso", int'(miso_bufe), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_miso", int'(miso_bufe), 0);
        expect_state("async_reset_state", IDLE);
        #2;
        reset = 1'b0;
        cycle();
        expect_state("reset_reenter_get_addr", GET_ADDR);
        cs = 1'b1;
        cycle();
        expect_state("reset_abort_idle", IDLE);

        // Back-to-back writes separated by one cs-high cycle
        d0 = dm_count;
        do_write();
        cs = 1'b1;
        cycle();
        expect_state("b2b_gap_idle", IDLE);
        do_write();
        cs = 1'b1;
        cycle();
        expect_state("b2b_end_idle", IDLE);
        check("b2b_dm_count", dm_count - d0, 2);

        cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_fsm.md
SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 Parameter: WIDTH, 8, bits per SPI frame phase (7 address bits + R/W bit; data byte).
REQ-002 Parameter: CNT_W, 4, bit-counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cs  input  1  conditioned chip select, active-low (0 = transaction in progress).
REQ-006 sclk_pos  input  1  one-clk pulse per rising serial-clock edge, from the input conditioner.
REQ-007 sclk_neg  input  1  one-clk pulse per falling serial-clock edge, from the input conditioner.
REQ-008 rw_bit  input  1  shift-register parallel output bit 0 (1 = read, 0 = write).
REQ-009 addr_we  output  1  one-clk strobe latching the address from the shift register.
REQ-010 sr_we  output  1  one-clk parallel-load strobe into the shift register (read data).
REQ-011 dm_we  output  1  one-clk data-memory write strobe.
REQ-012 miso_bufe  output  1  MISO tri-state buffer enable.
REQ-013 state_dbg  output  3  current state encoding, for LED display.

Function
REQ-014 States SHALL be: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_RECV, WRITE_COMMIT, DONE.
REQ-015 IDLE -> GET_ADDR when cs = 0; the bit counter SHALL clear to 0 on this transition.
REQ-016 The bit counter SHALL increment by 1 on each clk cycle with sclk_pos = 1 while in GET_ADDR, READ_SHIFT or WRITE_RECV, and SHALL hold otherwise.
REQ-017 GET_ADDR -> GOT_ADDR on the cycle the counter reaches WIDTH; the counter clears to 0.
REQ-018 GOT_ADDR SHALL last exactly one clk with addr_we = 1; next state is READ_LOAD if rw_bit = 1, else WRITE_RECV.
REQ-019 READ_LOAD SHALL last exactly one clk with sr_we = 1; next state is READ_SHIFT.
REQ-020 miso_bufe SHALL be 1 in READ_SHIFT only; READ_SHIFT -> DONE when the counter reaches WIDTH.
REQ-021 WRITE_RECV -> WRITE_COMMIT when the counter reaches WIDTH.
REQ-022 WRITE_COMMIT SHALL last exactly one clk with dm_we = 1; next state is DONE.
REQ-023 DONE SHALL hold all strobes at 0 until cs = 1, then go to IDLE.
REQ-024 cs = 1 in any state other than IDLE SHALL force the next state to IDLE, clear the counter, and suppress every strobe in that cycle (abort).
REQ-025 If cs rises on the same cycle the counter reaches WIDTH, the abort SHALL win: no addr_we and no dm_we.
REQ-026 Outputs SHALL be Moore (decoded from registered state only); each strobe SHALL be high for exactly one clk per transaction.
REQ-027 sclk_neg SHALL not change state; it is reserved for MISO timing and passed through unused.
REQ-028 The counter SHALL saturate at WIDTH and never wrap.

Reset
REQ-029 reset = 1 SHALL asynchronously force state IDLE, counter 0, and addr_we, sr_we, dm_we, miso_bufe = 0.
REQ-030 Reset asserted mid-transaction SHALL discard the transaction; after reset releases with cs = 0, the FSM SHALL re-enter GET_ADDR on the next clk.

Structure
REQ-031 The state encoding localparams and the CNT_W default SHALL live in a shared package, spi_fsm_pkg.
REQ-032 The bit counter SHALL be a separate sub-module, bit_counter (inputs clear, enable; output count).
REQ-033 No clock gating; sclk_pos and sclk_neg are used as enables only.

Verification
REQ-034 Write transaction: cs = 0, 8 sclk_pos pulses with rw_bit = 0 at the 8th, then 8 more -> exactly one addr_we, one dm_we, no sr_we, miso_bufe = 0 throughout; state ends in DONE.
REQ-035 Read transaction: as REQ-034 but rw_bit = 1 -> addr_we, then sr_we on the next clk, then miso_bufe = 1 for exactly 8 sclk_pos; no dm_we.
REQ-036 Abort: cs = 1 after 5 data pulses in WRITE_RECV -> IDLE on the next clk, dm_we never asserted.
REQ-037 Simultaneous event: cs = 1 on the same clk as the 8th sclk_pos in GET_ADDR -> IDLE, addr_we = 0.
REQ-038 Async reset: reset pulse in READ_SHIFT between clk edges -> miso_bufe = 0 immediately; state_dbg = IDLE.
REQ-039 Back-to-back: two write transactions separated by one cs-high cycle -> two dm_we strobes, counter cleared at each start.
